count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Controller that sequences the up/down counter datapath between the pulse-edge detector and the counter.
- Turns conditioned button pulses into counter enable and clear strobes.
- Supports single-step and free-run (prescaled tick) modes.
- Detects terminal count using the counter value fed back to it, then either wraps or halts.
- Reports mode and terminal status for the display path.

Parameters:
WIDTH, 32, width of the counter value fed back on q
TICK_DIV, 100000000, clk cycles per auto-increment in RUN; legal range is >= 2
MAX_COUNT, 32'hFFFFFFFF, terminal value when counting up; terminal value when counting down is 0
WRAP, 1, 1 = counting continues through the terminal value; 0 = counting halts at the terminal value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
step_p  input  1  one-cycle pulse: single count step
run_p  input  1  one-cycle pulse: toggle free-run
clr_p  input  1  one-cycle pulse: clear counter, return to IDLE
uphdnl  input  1  direction: 1 = up, 0 = down
q  input  WIDTH  current counter value (feedback)
cnt_en  output  1  one-cycle count strobe to counter
cnt_up  output  1  registered direction to counter
cnt_clr  output  1  one-cycle synchronous clear strobe to counter
mode  output  2  state: 00 IDLE, 01 RUN, 10 HALT
tc  output  1  registered terminal-count flag

Behaviour:
- All outputs are registered.
- Reset (rst = 0, asynchronous) forces:
  - mode = IDLE
  - cnt_en = 0, cnt_clr = 0, tc = 0
  - cnt_up = 1
  - prescaler = TICK_DIV-1
- cnt_up <= uphdnl every cycle, giving 1-cycle latency. Direction changes take effect on the next strobe.
- Terminal condition `term`, combinational:
  - (cnt_up && q == MAX_COUNT) || (!cnt_up && q == 0)
  - tc <= term every cycle.
- Strobe suppression: when WRAP = 0 and term = 1, no cnt_en is issued. When WRAP = 1, strobes are never suppressed; the counter wraps on its own.
- Command priority in the same cycle: clr_p > run_p > step_p.
- clr_p, from any state:
  - cnt_clr = 1 for exactly one cycle
  - mode -> IDLE
  - prescaler reloads TICK_DIV-1
  - no cnt_en that cycle
- IDLE:
  - step_p -> cnt_en = 1 for one cycle, unless suppressed.
  - run_p -> RUN, prescaler reloads TICK_DIV-1.
- RUN:
  - Prescaler decrements each cycle.
  - At 0: reload TICK_DIV-1 and issue cnt_en, unless suppressed.
  - If suppressed and WRAP = 0 -> HALT.
  - step_p is ignored.
  - run_p -> IDLE, prescaler reloads.
- HALT:
  - No strobes are issued.
  - run_p -> IDLE.
  - If term = 0 (direction was reversed): transition to RUN with prescaler reloaded.
  - step_p is ignored.
- Count latency:
  - Step: command pulse at cycle N -> cnt_en high at N+1 -> counter updates at N+2.
  - Terminal evaluation uses q as presented each cycle. TICK_DIV >= 2 guarantees q has settled before the next strobe decision.
- cnt_en and cnt_clr are never high in the same cycle.
- At most one cnt_en per step_p.
- Reset asserted mid-RUN: immediate return to reset values, with no residual strobe after release.

Test Plan (WIDTH=4, MAX_COUNT=15, TICK_DIV=4, bench counter model attached):
- Reset:
  - Stimulus: hold rst = 0 for 3 cycles, then release.
  - Required: mode = 00, tc = 0, cnt_up = 1, no strobes for 10 cycles.
- Step:
  - Stimulus: IDLE, uphdnl = 1, three step_p pulses 5 cycles apart.
  - Required: exactly 3 cnt_en pulses, each 1 cycle after its step_p; q goes 0 -> 3.
- Free-run:
  - Stimulus: run_p with q = 0.
  - Required: cnt_en every 4 cycles, first strobe 4 cycles after entering RUN.
  - Stimulus: second run_p after 5 strobes.
  - Required: mode = 00, q = 5.
- Halt, WRAP=0:
  - Stimulus: RUN up from q = 13.
  - Required: strobes take q to 15, then tc = 1, mode = 10, no further cnt_en.
  - Stimulus: uphdnl -> 0.
  - Required: mode = 01, q counts down 14, 13.
- Wrap, WRAP=1:
  - Stimulus: RUN up from q = 14.
  - Required: q goes 15 -> 0 -> 1; tc high only while q = 15; mode stays 01.
- Priority/clear:
  - Stimulus: clr_p, run_p and step_p in the same cycle during RUN.
  - Required: single cnt_clr, no cnt_en, mode = 00, q = 0.
  - Stimulus: rst pulsed low mid-prescale.
  - Required: no strobe afterwards.

Source files
------------

// File: rtl/count_sequencer.sv
// Sequencer between the button pulse conditioner and the up/down counter:
// issues count/clear strobes for single-step and prescaled free-run modes.
module count_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      TICK_DIV  = 100000000,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_p,
  input  logic             run_p,
  input  logic             clr_p,
  input  logic             uphdnl,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic [1:0]       mode,
  output logic             tc
);

  localparam int unsigned   PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] RELOAD = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] ZERO   = {PW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          cnt_en_q;
  logic          cnt_clr_q;
  logic          cnt_up_q;
  logic          tc_q;
  logic          term_s;
  logic          suppress_s;

  // Terminal value depends on the direction already presented to the counter.
  always_comb begin
    term_s = 1'b0;
    if (cnt_up_q) begin
      term_s = (q == MAX_COUNT);
    end else begin
      term_s = (q == {WIDTH{1'b0}});
    end
    suppress_s = !WRAP && term_s;
  end

  // Command decode, prescaler and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= RELOAD;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      cnt_up_q  <= 1'b1;
      tc_q      <= 1'b0;
    end else begin
      cnt_up_q  <= uphdnl;
      tc_q      <= term_s;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      if (clr_p) begin
        cnt_clr_q <= 1'b1;
        state_q   <= ST_IDLE;
        presc_q   <= RELOAD;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_p) begin
              state_q <= ST_RUN;
              presc_q <= RELOAD;
            end else if (step_p) begin
              cnt_en_q <= !suppress_s;
            end
          end
          ST_RUN: begin
            if (run_p) begin
              state_q <= ST_IDLE;
              presc_q <= RELOAD;
            end else if (presc_q == ZERO) begin
              presc_q <= RELOAD;
              if (suppress_s) begin
                state_q <= ST_HALT;
              end else begin
                cnt_en_q <= 1'b1;
              end
            end else begin
              presc_q <= presc_q - ONE;
            end
          end
          ST_HALT: begin
            // Leaving terminal (direction reversed) resumes free-run.
            if (run_p) begin
              state_q <= ST_IDLE;
              presc_q <= RELOAD;
            end else if (!term_s) begin
              state_q <= ST_RUN;
              presc_q <= RELOAD;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            presc_q <= RELOAD;
          end
        endcase
      end
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign cnt_up  = cnt_up_q;
  assign tc      = tc_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a WRAP=0 and a WRAP=1 instance, each closing the
// loop through its own up/down counter, checked every cycle against a model.
module tb_count_sequencer;

  localparam int              W    = 4;
  localparam int              TD   = 4;
  localparam logic [W-1:0]    MAXC = 4'd15;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_p;
  logic         run_p;
  logic         clr_p;
  logic         uphdnl;
  logic [W-1:0] q_v    [2];
  logic         en_s   [2];
  logic         up_s   [2];
  logic         clr_s  [2];
  logic         tc_s   [2];
  logic [1:0]   mode_s [2];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: index 0 is WRAP=0, index 1 is WRAP=1.
  int   m_mode [2];
  int   m_age  [2];
  logic m_en   [2];
  logic m_clr  [2];
  logic m_up   [2];
  logic m_tc   [2];
  logic en_pre [2];
  logic clr_pre[2];
  logic up_pre [2];
  int   en_cnt [2];
  int   clr_cnt[2];

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .TICK_DIV(TD), .MAX_COUNT(MAXC), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .rst(rst), .step_p(step_p), .run_p(run_p), .clr_p(clr_p),
    .uphdnl(uphdnl), .q(q_v[0]), .cnt_en(en_s[0]), .cnt_up(up_s[0]),
    .cnt_clr(clr_s[0]), .mode(mode_s[0]), .tc(tc_s[0])
  );

  count_sequencer #(.WIDTH(W), .TICK_DIV(TD), .MAX_COUNT(MAXC), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .step_p(step_p), .run_p(run_p), .clr_p(clr_p),
    .uphdnl(uphdnl), .q(q_v[1]), .cnt_en(en_s[1]), .cnt_up(up_s[1]),
    .cnt_clr(clr_s[1]), .mode(mode_s[1]), .tc(tc_s[1])
  );

  task automatic check(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset(input int w);
    m_mode[w] = 0;
    m_age[w]  = 0;
    m_en[w]   = 1'b0;
    m_clr[w]  = 1'b0;
    m_up[w]   = 1'b1;
    m_tc[w]   = 1'b0;
  endtask

  // Free-run strobes fall on every TD-th cycle counted from entry into RUN.
  task automatic model_step(input int w);
    logic term;
    logic sup;
    term = m_up[w] ? (q_v[w] == MAXC) : (q_v[w] == 4'd0);
    sup  = (w == 0) && term;
    m_en[w]  = 1'b0;
    m_clr[w] = 1'b0;
    m_tc[w]  = term;
    if (clr_p) begin
      m_clr[w]  = 1'b1;
      m_mode[w] = 0;
    end else if (m_mode[w] == 0) begin
      if (run_p) begin
        m_mode[w] = 1;
        m_age[w]  = 0;
      end else if (step_p) begin
        m_en[w] = !sup;
      end
    end else if (m_mode[w] == 1) begin
      if (run_p) begin
        m_mode[w] = 0;
      end else begin
        m_age[w]++;
        if (m_age[w] % TD == 0) begin
          if (sup) m_mode[w] = 2;
          else     m_en[w]   = 1'b1;
        end
      end
    end else begin
      if (run_p) begin
        m_mode[w] = 0;
      end else if (!term) begin
        m_mode[w] = 1;
        m_age[w]  = 0;
      end
    end
    m_up[w] = uphdnl;
  endtask

  task automatic compare(input int w);
    check($sformatf("cnt_en[%0d]", w),  int'(en_s[w]),   int'(m_en[w]));
    check($sformatf("cnt_clr[%0d]", w), int'(clr_s[w]),  int'(m_clr[w]));
    check($sformatf("cnt_up[%0d]", w),  int'(up_s[w]),   int'(m_up[w]));
    check($sformatf("mode[%0d]", w),    int'(mode_s[w]), m_mode[w]);
    check($sformatf("tc[%0d]", w),      int'(tc_s[w]),   int'(m_tc[w]));
  endtask

  // One clock: drive at negedge, counter responds and outputs are checked after posedge.
  task automatic tick(input logic s, input logic r, input logic c);
    step_p = s;
    run_p  = r;
    clr_p  = c;
    for (int w = 0; w < 2; w++) begin
      en_pre[w]  = en_s[w];
      clr_pre[w] = clr_s[w];
      up_pre[w]  = up_s[w];
      model_step(w);
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      if (clr_pre[w])     q_v[w] = 4'd0;
      else if (en_pre[w]) q_v[w] = up_pre[w] ? q_v[w] + 4'd1 : q_v[w] - 4'd1;
      if (en_s[w])  en_cnt[w]++;
      if (clr_s[w]) clr_cnt[w]++;
      compare(w);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    step_p = 1'b0;
    run_p  = 1'b0;
    clr_p  = 1'b0;
    for (int w = 0; w < 2; w++) begin
      model_reset(w);
      q_v[w] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) compare(w);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    int first;
    logic [W-1:0] prev;
    rst    = 1'b0;
    uphdnl = 1'b1;
    step_p = 1'b0;
    run_p  = 1'b0;
    clr_p  = 1'b0;
    q_v[0] = 4'd0;
    q_v[1] = 4'd0;
    en_cnt  = '{0, 0};
    clr_cnt = '{0, 0};
    for (int w = 0; w < 2; w++) model_reset(w);
    @(negedge clk);

    // Reset and quiet period
    do_reset();
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    check("reset_quiet_strobes", en_cnt[0] + en_cnt[1], 0);

    // Single steps
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      check($sformatf("step_en_%0d", k), int'(en_s[0]), 1);
      repeat (4) tick(1'b0, 1'b0, 1'b0);
    end
    check("step_q0", int'(q_v[0]), 3);
    check("step_q1", int'(q_v[1]), 3);
    check("step_count", en_cnt[0], 3);

    // Free-run from zero
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("clr_q", int'(q_v[0]), 0);
    en_cnt = '{0, 0};
    first  = -1;
    n      = 0;
    tick(1'b0, 1'b1, 1'b0);
    while (en_cnt[0] < 5 && n < 60) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
      if (en_cnt[0] == 1 && first < 0) first = n;
    end
    check("run_first_gap", first, TD);
    check("run_five_strobes", n, 5 * TD);
    tick(1'b0, 1'b1, 1'b0);
    check("run_stop_mode", int'(mode_s[0]), 0);
    check("run_stop_q", int'(q_v[0]), 5);

    // Halt at terminal with WRAP=0, then reverse direction
    q_v[0] = 4'd13;
    q_v[1] = 4'd13;
    tick(1'b0, 1'b1, 1'b0);
    n = 0;
    while (mode_s[0] != 2'b10 && n < 40) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("halt_mode", int'(mode_s[0]), 2);
    check("halt_q", int'(q_v[0]), 15);
    check("halt_tc", int'(tc_s[0]), 1);
    en_cnt = '{0, 0};
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    check("halt_no_strobe", en_cnt[0], 0);
    uphdnl = 1'b0;
    n = 0;
    while (mode_s[0] != 2'b01 && n < 10) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("resume_mode", int'(mode_s[0]), 1);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    check("resume_down_q", int'(q_v[0]), 13);

    // Wrap through terminal with WRAP=1
    uphdnl = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    q_v[0] = 4'd14;
    q_v[1] = 4'd14;
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      prev = q_v[1];
      tick(1'b0, 1'b0, 1'b0);
      check("wrap_tc", int'(tc_s[1]), int'(prev == 4'd15));
      check("wrap_mode", int'(mode_s[1]), 1);
    end
    check("wrap_q", int'(q_v[1]), 1);

    // Simultaneous clear/run/step during RUN: clear wins
    clr_cnt = '{0, 0};
    en_cnt  = '{0, 0};
    tick(1'b1, 1'b1, 1'b1);
    check("prio_clr", int'(clr_s[1]), 1);
    check("prio_en", int'(en_s[1]), 0);
    check("prio_mode", int'(mode_s[1]), 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("prio_q", int'(q_v[1]), 0);
    check("prio_single_clr", clr_cnt[1], 1);
    check("prio_no_en", en_cnt[1], 0);

    // Asynchronous reset in the middle of a prescale period
    tick(1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      model_reset(w);
      q_v[w] = 4'd0;
      compare(w);
    end
    @(negedge clk);
    rst = 1'b1;
    en_cnt = '{0, 0};
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    check("rst_mid_no_strobe", en_cnt[0] + en_cnt[1], 0);

    // Randomized command traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) uphdnl = ~uphdnl;
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
